cdp_rdma_group_ctrl: RTL
========================

Name: cdp_rdma_group_ctrl

Overview:
Ping-pong register-group scheduler for the CDP RDMA. It tracks the per-group op_en flags written by software through the producer-selected group. It sequences the datapath through load/run/done for the group named by consumer. It drives the consumer pointer and the status_0/status_1 fields read back through the single register file.

Parameters:
CFG_LAT, 2, cycles spent in LOAD for config propagation to the datapath (1..15).
TO_W, 16, width of the RUN watchdog counter.
TO_EN, 0, 1 enables the watchdog; 0 removes it (timeout_err tied 0).

Ports:
nvdla_core_clk  input  1  core clock
nvdla_core_rst  input  1  synchronous, active-high reset
producer  input  1  software-selected group for op_en writes
op_en_wr  input  1  write strobe to D_OP_ENABLE of group[producer]
op_en_wdata  input  1  bit0 of write data
dp_done  input  1  single-cycle datapath completion pulse
consumer  output  1  group currently or next executed
status_0  output  2  group 0 status: 0 IDLE, 1 RUNNING, 2 PENDING
status_1  output  2  group 1 status, same encoding
op_en_0  output  1  group 0 enable flag
op_en_1  output  1  group 1 enable flag
op_load  output  1  one-cycle pulse: latch config of op_load_grp
op_load_grp  output  1  group being loaded
dp_busy  output  1  high in LOAD and RUN
done_intr  output  1  one-cycle completion pulse
done_intr_grp  output  1  group that completed
op_en_err  output  1  pulse: op_en=1 write to an already enabled group
done_err  output  1  pulse: dp_done outside RUN
timeout_err  output  1  pulse: watchdog expired

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0. Reset mid-operation aborts immediately and produces no done_intr.
- Clock and reset: single clock nvdla_core_clk; synchronous active-high reset nvdla_core_rst.
- op_en[g] register:
  - set on op_en_wr & op_en_wdata & producer==g & !op_en[g], visible next cycle;
  - op_en_wr with wdata=1 to an enabled group: dropped, op_en_err pulses the next cycle;
  - op_en_wr with wdata=0: ignored, software cannot cancel;
  - cleared in the DONE cycle for g==consumer.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE -> LOAD when op_en[consumer]==1. op_load=1 and op_load_grp=consumer in the first LOAD cycle only.
  - LOAD holds CFG_LAT cycles via a down-counter, then -> RUN.
  - RUN -> DONE on dp_done. With TO_EN=1, RUN also -> DONE when the watchdog hits all-ones; timeout_err pulses in that cycle.
  - Watchdog clears on entering RUN.
  - DONE lasts one cycle: done_intr=1, done_intr_grp=consumer, op_en[consumer] cleared, consumer toggles at cycle end. Then -> IDLE.
- Latency: op_en write in cycle N gives op_en visible at N+1, LOAD and op_load at N+2, RUN at N+2+CFG_LAT.
- Back-to-back: if the other group is already enabled at DONE, IDLE at cycle D+1 goes to LOAD at D+2. No IDLE skip.
- dp_done in IDLE, LOAD or DONE: ignored, done_err pulses the next cycle.
- Same-cycle events:
  - an op_en set to the non-consumer group during DONE is accepted;
  - a set to the consumer group during DONE is rejected with op_en_err, because the flag is still 1 that cycle.
- Status decode, combinational from registers:
  - IDLE if !op_en[g];
  - RUNNING if op_en[g] & g==consumer & state in LOAD, RUN or DONE;
  - else PENDING.
- consumer changes only in DONE. The producer value is never modified here.

Decomposition:
- Shared package cdp_rdma_pkg:
  - status encodings ST_IDLE=2'd0, ST_RUNNING=2'd1, ST_PENDING=2'd2;
  - FSM state enum (2 bits).
- One sub-module, cdp_rdma_grp_flag: per-group op_en flag with set/clear/err logic, instantiated twice. The FSM and counters are inline.

Test Plan:
- Single op, CFG_LAT=2: op_en_wr, producer=0, wdata=1 at cycle 0.
  - op_en_0=1 at cycle 1; op_load=1, grp=0 at cycle 2; dp_busy at cycles 2..;
  - dp_done at cycle 10 gives done_intr grp0 at cycle 11, op_en_0=0 and consumer=1 at cycle 12;
  - status_0 reads 1 during cycles 2..11, then 0.
- Ping-pong: enable g0 and g1 back-to-back.
  - status_1 reads 2 (PENDING) while g0 runs;
  - after g0 DONE at cycle D, op_load grp=1 at D+2;
  - after g1 completes, consumer returns to 0.
- Double enable: second op_en_wr to g0 while op_en_0=1 -> op_en_err pulse, no extra op_load.
- Stray dp_done in IDLE -> done_err pulse, state stays IDLE, no done_intr.
- Watchdog, TO_EN=1, TO_W=4: no dp_done -> timeout_err plus done_intr 15 cycles after RUN entry, op_en cleared.
- Reset in RUN: nvdla_core_rst for 1 cycle -> all outputs 0 next cycle, consumer=0, no done_intr.

Source files
------------

// File: rtl/cdp_rdma_group_ctrl_pkg.sv
// Shared types for the CDP RDMA ping-pong group scheduler: status encodings,
// FSM state type and the per-group status decode.
package cdp_rdma_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } grp_state_e;

  function automatic logic [1:0] grp_status(input logic en, input logic is_cons,
                                            input logic active);
    if (!en) return ST_IDLE;
    if (is_cons && active) return ST_RUNNING;
    return ST_PENDING;
  endfunction

endpackage

// File: rtl/cdp_rdma_group_ctrl_if.sv
// Register-file / datapath side signals of the CDP RDMA group scheduler.
interface cdp_rdma_group_ctrl_if;

  logic       producer;
  logic       op_en_wr;
  logic       op_en_wdata;
  logic       dp_done;
  logic       consumer;
  logic [1:0] status_0;
  logic [1:0] status_1;
  logic       op_en_0;
  logic       op_en_1;
  logic       op_load;
  logic       op_load_grp;
  logic       dp_busy;
  logic       done_intr;
  logic       done_intr_grp;
  logic       op_en_err;
  logic       done_err;
  logic       timeout_err;

  modport master (
    output producer, op_en_wr, op_en_wdata, dp_done,
    input  consumer, status_0, status_1, op_en_0, op_en_1, op_load, op_load_grp,
           dp_busy, done_intr, done_intr_grp, op_en_err, done_err, timeout_err
  );

  modport slave (
    input  producer, op_en_wr, op_en_wdata, dp_done,
    output consumer, status_0, status_1, op_en_0, op_en_1, op_load, op_load_grp,
           dp_busy, done_intr, done_intr_grp, op_en_err, done_err, timeout_err
  );

endinterface

// File: rtl/cdp_rdma_group_ctrl_grp_flag.sv
// Per-group op_en flag: software may set it, only the scheduler clears it.
module cdp_rdma_grp_flag (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rst,
  input  logic wr_en,
  input  logic wdata,
  input  logic clr,
  output logic op_en,
  output logic op_en_err
);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      op_en     <= 1'b0;
      op_en_err <= 1'b0;
    end else begin
      // A set to an already enabled group is dropped, even if it is cleared this cycle
      op_en_err <= wr_en & wdata & op_en;
      if (clr)
        op_en <= 1'b0;
      else if (wr_en & wdata)
        op_en <= 1'b1;
    end
  end

endmodule

// File: rtl/cdp_rdma_group_ctrl.sv
// Ping-pong register-group scheduler: sequences LOAD/RUN/DONE for the consumer
// group and reports per-group status to the register file.
module cdp_rdma_group_ctrl
  import cdp_rdma_pkg::*;
#(
  parameter int unsigned CFG_LAT = 2,
  parameter int unsigned TO_W    = 16,
  parameter bit          TO_EN   = 1'b0
) (
  input logic                  nvdla_core_clk,
  input logic                  nvdla_core_rst,
  cdp_rdma_group_ctrl_if.slave bus
);

  localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(CFG_LAT - 1);
  localparam logic [TO_W-1:0]  WDOG_MAX  = '1;
  localparam logic [TO_W-1:0]  WDOG_PRE  = WDOG_MAX - TO_W'(1);

  grp_state_e       state, state_nxt;
  logic             consumer_q;
  logic [LAT_W-1:0] lat_cnt;
  logic [TO_W-1:0]  wdog;
  logic             done_err_q;
  logic             timeout_q;
  logic             timeout_set;
  logic             wdog_hit;
  logic             cons_en;
  logic [1:0]       op_en;
  logic [1:0]       flag_err;
  logic             active;

  cdp_rdma_grp_flag u_flag0 (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .wr_en          (bus.op_en_wr & ~bus.producer),
    .wdata          (bus.op_en_wdata),
    .clr            ((state == S_DONE) & ~consumer_q),
    .op_en          (op_en[0]),
    .op_en_err      (flag_err[0])
  );

  cdp_rdma_grp_flag u_flag1 (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .wr_en          (bus.op_en_wr & bus.producer),
    .wdata          (bus.op_en_wdata),
    .clr            ((state == S_DONE) & consumer_q),
    .op_en          (op_en[1]),
    .op_en_err      (flag_err[1])
  );

  assign cons_en = consumer_q ? op_en[1] : op_en[0];

  // Decided one cycle early so timeout_err is registered and lands with DONE,
  // the cycle in which the watchdog reads all-ones
  assign wdog_hit = TO_EN && (state == S_RUN) && (wdog == WDOG_PRE);

  always_comb begin
    state_nxt   = state;
    timeout_set = 1'b0;
    unique case (state)
      S_IDLE: if (cons_en) state_nxt = S_LOAD;
      S_LOAD: if (lat_cnt == '0) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.dp_done) begin
          state_nxt = S_DONE;
        end else if (wdog_hit) begin
          state_nxt   = S_DONE;
          timeout_set = 1'b1;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state      <= S_IDLE;
      consumer_q <= 1'b0;
      lat_cnt    <= '0;
      wdog       <= '0;
      done_err_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      done_err_q <= bus.dp_done & (state != S_RUN);
      timeout_q  <= timeout_set;
      if (state == S_IDLE && state_nxt == S_LOAD)
        lat_cnt <= LAT_INIT;
      else if (state == S_LOAD && lat_cnt != '0)
        lat_cnt <= lat_cnt - 1'b1;
      if (state == S_LOAD && state_nxt == S_RUN)
        wdog <= '0;
      else if (state == S_RUN)
        wdog <= wdog + 1'b1;
      if (state == S_DONE)
        consumer_q <= ~consumer_q;
    end
  end

  assign active            = (state != S_IDLE);
  assign bus.consumer      = consumer_q;
  assign bus.op_en_0       = op_en[0];
  assign bus.op_en_1       = op_en[1];
  assign bus.status_0      = grp_status(op_en[0], ~consumer_q, active);
  assign bus.status_1      = grp_status(op_en[1], consumer_q, active);
  assign bus.op_load       = (state == S_LOAD) && (lat_cnt == LAT_INIT);
  assign bus.op_load_grp   = bus.op_load & consumer_q;
  assign bus.dp_busy       = (state == S_LOAD) || (state == S_RUN);
  assign bus.done_intr     = (state == S_DONE);
  assign bus.done_intr_grp = (state == S_DONE) & consumer_q;
  assign bus.op_en_err     = |flag_err;
  assign bus.done_err      = done_err_q;
  assign bus.timeout_err   = timeout_q;

endmodule
